// File: rtl/hdb3_pkg.sv
// Shared symbol encoding and limits for the HDB3 dual-rail receive decoder.
// Symbols are the concatenation {ipos, ineg} sampled on each line clock.
package hdb3_pkg;

  typedef enum logic [1:0] {
    SYM_ZERO = 2'b00,
    SYM_NEG  = 2'b01,
    SYM_POS  = 2'b10,
    SYM_ILL  = 2'b11
  } sym_e;

  // A legal HDB3 line never carries more than three zeros in a row.
  localparam int ZRUN_MAX   = 4;
  localparam int LOSTHR_DEF = 255;

  typedef struct packed {
    logic mark;  // exactly one rail high
    logic pol;   // 1 = positive mark
    logic ill;   // both rails high
  } sym_t;

  function automatic sym_t classify(input sym_e sym);
    sym_t s;
    s.mark = (sym == SYM_POS) || (sym == SYM_NEG);
    s.pol  = (sym == SYM_POS);
    s.ill  = (sym == SYM_ILL);
    return s;
  endfunction

endpackage

// File: rtl/hdb3losdt.sv
// Loss-of-signal detector: counts consecutive symbols without a mark and
// raises olos once the run reaches LOSTHR; the first mark clears it.
module hdb3losdt #(
  parameter int LOSTHR = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic quiet,
  output logic olos
);

  localparam logic [7:0] THR = 8'(LOSTHR);

  logic [7:0] loscnt_q, loscnt_d;
  logic       los_q, los_d;

  always_comb begin
    loscnt_d = '0;
    if (quiet) begin
      loscnt_d = (loscnt_q == THR) ? loscnt_q : loscnt_q + 8'd1;
    end
    los_d = quiet && (loscnt_d == THR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      loscnt_q <= '0;
      los_q    <= 1'b0;
    end else begin
      loscnt_q <= loscnt_d;
      los_q    <= los_d;
    end
  end

  assign olos = los_q;

endmodule

// File: rtl/hdb3dc.sv
// Dual-rail HDB3 decoder: strips B00V/000V substitutions, flags and counts
// code violations. Optional loss-of-signal detection under HDB3DEC_LOS_EN.
module hdb3dc
  import hdb3_pkg::*;
#(
  parameter int CVW    = 16,
  parameter int LOSTHR = LOSTHR_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ipos,
  input  logic           ineg,
  input  logic           iclr,
  output logic           odat,
  output logic           ocv,
  output logic [CVW-1:0] ocvcnt,
  output logic           olos
);

  localparam int ZW = $clog2(ZRUN_MAX + 1);
  localparam logic [ZW-1:0] ZMAX = ZW'(ZRUN_MAX);

  if (LOSTHR < 1 || LOSTHR > 255) begin : g_losthr_range
    $error("hdb3dc: LOSTHR must lie in 1..255");
  end

  sym_t sym;
  logic is_v;
  logic cv;

  logic           lastpol_q, lastpol_d;
  logic           seen_q, seen_d;
  logic           lastvpol_q, lastvpol_d;
  logic           vseen_q, vseen_d;
  logic [3:0]     sr_q, sr_d;
  logic [ZW-1:0]  zrun_q, zrun_d;
  logic           odat_q, odat_d;
  logic           ocv_q, ocv_d;
  logic [CVW-1:0] ocvcnt_q, ocvcnt_d;

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    sym        = classify(sym_e'({ipos, ineg}));
    lastpol_d  = lastpol_q;
    seen_d     = seen_q;
    lastvpol_d = lastvpol_q;
    vseen_d    = vseen_q;

    is_v = sym.mark && seen_q && (sym.pol == lastpol_q);

    if (sym.mark) begin
      lastpol_d = sym.pol;
      seen_d    = 1'b1;
    end
    if (is_v) begin
      lastvpol_d = sym.pol;
      vseen_d    = 1'b1;
    end

    // A V wipes itself and the three slots behind it (B00 or 000); the
    // oldest slot in sr[3] has already been handed to the output register.
    sr_d   = is_v ? 4'b0000 : {sr_q[2:0], sym.mark};
    odat_d = sr_q[3];

    zrun_d = '0;
    if (!sym.mark) begin
      zrun_d = (zrun_q == ZMAX) ? zrun_q : zrun_q + ZW'(1);
    end

    cv = sym.ill
       | (is_v && (sr_q[1:0] != 2'b00))
       | (is_v && vseen_q && (sym.pol == lastvpol_q))
       | (!sym.mark && (zrun_q == ZMAX - ZW'(1)));
    ocv_d = cv;

    ocvcnt_d = ocvcnt_q;
    if (iclr) begin
      ocvcnt_d = '0;
    end else if (cv && !(&ocvcnt_q)) begin
      ocvcnt_d = ocvcnt_q + CVW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its peers; reset is asynchronous and active-low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lastpol_q  <= 1'b0;
      seen_q     <= 1'b0;
      lastvpol_q <= 1'b0;
      vseen_q    <= 1'b0;
      sr_q       <= '0;
      zrun_q     <= '0;
      odat_q     <= 1'b0;
      ocv_q      <= 1'b0;
      ocvcnt_q   <= '0;
    end else begin
      lastpol_q  <= lastpol_d;
      seen_q     <= seen_d;
      lastvpol_q <= lastvpol_d;
      vseen_q    <= vseen_d;
      sr_q       <= sr_d;
      zrun_q     <= zrun_d;
      odat_q     <= odat_d;
      ocv_q      <= ocv_d;
      ocvcnt_q   <= ocvcnt_d;
    end
  end

  assign odat   = odat_q;
  assign ocv    = ocv_q;
  assign ocvcnt = ocvcnt_q;

`ifdef HDB3DEC_LOS_EN
  hdb3losdt #(
    .LOSTHR (LOSTHR)
  ) u_losdt (
    .clk   (clk),
    .rst   (rst),
    .quiet (!sym.mark),
    .olos  (olos)
  );
`else
  assign olos = 1'b0;
`endif

endmodule

// File: tb/tb_hdb3dc.sv
// Self-checking bench for hdb3dc: directed HDB3 patterns plus randomized
// symbols compared every cycle against a history-based decoding model.
module tb_hdb3dc;

  localparam int CVW    = 4;
  localparam int LOSTHR = 8;
`ifdef HDB3DEC_LOS_EN
  localparam bit LOS_EN = 1'b1;
`else
  localparam bit LOS_EN = 1'b0;
`endif

  localparam logic [1:0] P = 2'b10;
  localparam logic [1:0] N = 2'b01;
  localparam logic [1:0] Z = 2'b00;
  localparam logic [1:0] I = 2'b11;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           ipos = 1'b0;
  logic           ineg = 1'b0;
  logic           iclr = 1'b0;
  logic           odat;
  logic           ocv;
  logic [CVW-1:0] ocvcnt;
  logic           olos;

  hdb3dc #(
    .CVW    (CVW),
    .LOSTHR (LOSTHR)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ipos   (ipos),
    .ineg   (ineg),
    .iclr   (iclr),
    .odat   (odat),
    .ocv    (ocv),
    .ocvcnt (ocvcnt),
    .olos   (olos)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-symbol decoded-bit history with V substitutions
  // applied retroactively; odat replays the history four symbols late.
  bit data[$];
  int n;
  bit m_lastpol, m_seen, m_lastvpol, m_vseen;
  int zr;
  bit e_odat, e_ocv, e_los;
  int e_cnt;
  bit chk_en = 1'b0;

  task automatic model_reset();
    data.delete();
    n = 0;
    m_lastpol = 0; m_seen = 0; m_lastvpol = 0; m_vseen = 0;
    zr = 0;
    e_odat = 0; e_ocv = 0; e_cnt = 0; e_los = 0;
  endtask

  task automatic model_step(input logic [1:0] s, input logic clr);
    bit mark, pol, ill, isv, cv, d1, d2;
    mark = s[1] ^ s[0];
    ill  = s[1] & s[0];
    pol  = s[1];
    cv   = ill;
    isv  = mark && m_seen && (pol == m_lastpol);
    if (isv) begin
      d1 = (n >= 1) ? data[n-1] : 1'b0;
      d2 = (n >= 2) ? data[n-2] : 1'b0;
      if (d1 || d2) cv = 1;
      if (m_vseen && pol == m_lastvpol) cv = 1;
      m_vseen = 1;
      m_lastvpol = pol;
    end
    if (mark) begin
      m_lastpol = pol;
      m_seen = 1;
      zr = 0;
    end else begin
      zr++;
      if (zr == 4) cv = 1;
    end
    data.push_back(mark && !isv);
    if (isv) begin
      for (int j = n - 3; j < n; j++)
        if (j >= 0) data[j] = 1'b0;
    end
    e_odat = (n >= 4) ? data[n-4] : 1'b0;
    n++;
    e_ocv = cv;
    if (clr) e_cnt = 0;
    else if (cv && e_cnt < (1 << CVW) - 1) e_cnt++;
    e_los = LOS_EN && (zr >= LOSTHR);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("odat",   odat,   e_odat);
      check("ocv",    ocv,    e_ocv);
      check("ocvcnt", ocvcnt, e_cnt);
      check("olos",   olos,   e_los);
    end
  end

  task automatic step(input logic [1:0] s, input logic clr);
    ipos = s[1];
    ineg = s[0];
    iclr = clr;
    @(posedge clk);
    model_step(s, clr);
    chk_en = 1'b1;
    @(negedge clk);
    #1;
    iclr = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_odat"},   odat,   0);
    check({tag, "_ocv"},    ocv,    0);
    check({tag, "_ocvcnt"}, ocvcnt, 0);
    check({tag, "_olos"},   olos,   0);
  endtask

  logic [1:0] seq0 [25] = '{P, Z, N, Z, P, N, P, N, P, Z, Z, Z, P,
                            N, P, N, P, N, Z, Z, N, P, N, P, N};
  bit ami_exp [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    logic [1:0] s;
    logic [1:0] opp, same;
    int r;

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    // AMI, then 000V, then B00V
    for (int i = 0; i < 25; i++) begin
      step(seq0[i], 1'b0);
      if (i >= 4 && i <= 8) check("ami_odat", odat, ami_exp[i-4]);
      if (i >= 13 && i <= 16) check("sub000v_odat", odat, 0);
      if (i >= 21) check("b00v_odat", odat, 0);
      if (i == 12 || i == 20) check("sub_no_cv", ocv, 0);
    end
    check("clean_cnt", ocvcnt, 0);

    // V preceded by a single zero
    step(P, 1'b0);
    step(Z, 1'b0);
    step(P, 1'b0);
    check("short_v_ocv", ocv, 1);
    check("short_v_cnt", ocvcnt, 1);
    step(N, 1'b0);
    check("after_v_ocv", ocv, 0);

    // illegal symbol, then clear colliding with a further CV
    step(I, 1'b0);
    check("ill_ocv", ocv, 1);
    check("ill_cnt", ocvcnt, 2);
    step(P, 1'b0);
    step(I, 1'b1);
    check("clr_pri_ocv", ocv, 1);
    check("clr_pri_cnt", ocvcnt, 0);
    step(N, 1'b0);
    step(P, 1'b0);
    check("ill_odat", odat, 0);

    // long zero run: one CV at the 4th zero, LOS at the LOSTHR-th
    for (int i = 1; i <= 8; i++) begin
      step(Z, 1'b0);
      if (i == 4) check("zrun4_ocv", ocv, 1);
      if (i == 5) check("zrun5_ocv", ocv, 0);
      if (i == 7) check("los_pre", olos, 0);
      if (i == 8) check("los_set", olos, LOS_EN);
    end
    check("zrun_cnt", ocvcnt, 1);
    step(N, 1'b0);
    check("los_clr", olos, 0);

    // randomized traffic with legal substitutions mixed in
    for (int k = 0; k < 700; k++) begin
      opp  = m_lastpol ? N : P;
      same = m_lastpol ? P : N;
      r = $urandom_range(0, 99);
      if (r < 8) begin
        if ($urandom_range(0, 1) == 0) begin
          step(Z, 1'b0); step(Z, 1'b0); step(Z, 1'b0); step(same, 1'b0);
        end else begin
          step(opp, 1'b0); step(Z, 1'b0); step(Z, 1'b0); step(opp, 1'b0);
        end
      end else begin
        if (r < 40)      s = Z;
        else if (r < 80) s = opp;
        else if (r < 92) s = same;
        else             s = I;
        step(s, ($urandom_range(0, 39) == 0));
      end
      if (k == 350) begin
        chk_en = 1'b0;
        #2 rst = 1'b0;
        #1 check_reset_outputs("midrst");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
      end
    end

    // counter saturation
    step(Z, 1'b1);
    for (int i = 0; i < 20; i++) step(I, 1'b0);
    check("sat_cnt", ocvcnt, (1 << CVW) - 1);
    step(Z, 1'b1);
    check("sat_clr", ocvcnt, 0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
